// File: rtl/gfx_pkg.sv
// Shared graphics types: coordinate width, screen size, segment layout and dispatcher states.
// Also provides the coordinate clamp helper.
package gfx_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } segment_t;

    typedef enum logic [2:0] {
        StIdle,
        StERd,
        StEGo,
        StEWait,
        StDPop,
        StDLat,
        StDWait
    } dispatch_state_t;

    function automatic coord_t clamp_coord(coord_t v, coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/segment_dispatcher_if.sv
// Frame-control, segment FIFO and line_drawer signals seen by the segment dispatcher.
// The master modport is the dispatcher side; slave is the FIFO/drawer/system side.
interface segment_dispatcher_if;
    import gfx_pkg::*;

    logic   frame_start;
    logic   fifo_empty;
    logic   [4*COORD_W-1:0] fifo_q;
    logic   fifo_rdreq;
    coord_t ld_x0;
    coord_t ld_y0;
    coord_t ld_x1;
    coord_t ld_y1;
    logic   ld_color;
    logic   ld_start;
    logic   ld_done;
    logic   busy;
    logic   overflow;
    logic   frame_overrun;

    modport master (
        input  frame_start, fifo_empty, fifo_q, ld_done,
        output fifo_rdreq, ld_x0, ld_y0, ld_x1, ld_y1, ld_color, ld_start,
        output busy, overflow, frame_overrun
    );

    modport slave (
        output frame_start, fifo_empty, fifo_q, ld_done,
        input  fifo_rdreq, ld_x0, ld_y0, ld_x1, ld_y1, ld_color, ld_start,
        input  busy, overflow, frame_overrun
    );

endinterface

// File: rtl/segment_history.sv
// History of segments drawn in the previous frame: synchronous write, registered read
// with one cycle of latency. Contents are not reset.
module segment_history
    import gfx_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  segment_t      wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output segment_t      rdata
);

    segment_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/segment_dispatcher.sv
// Per frame: erase last frame's segments (colour 0), then pop and draw new ones (colour 1),
// one line in flight at a time via the ld_start/ld_done handshake.
module segment_dispatcher
    import gfx_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned X_MAX = SCREEN_W - 1,
    parameter int unsigned Y_MAX = SCREEN_H - 1
) (
    input logic                 clk,
    input logic                 reset,
    segment_dispatcher_if.master bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam coord_t      XLIM = coord_t'(X_MAX);
    localparam coord_t      YLIM = coord_t'(Y_MAX);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    dispatch_state_t state;
    logic [PW-1:0]   hist_count;
    logic [PW-1:0]   erase_ptr;
    logic [PW-1:0]   wr_ptr;
    segment_t        fifo_seg;
    segment_t        clamped;
    segment_t        hist_rdata;
    logic            hist_we;
    logic            hist_re;

    assign fifo_seg = segment_t'(bus.fifo_q);
    assign clamped  = {clamp_coord(fifo_seg.x0, XLIM), clamp_coord(fifo_seg.y0, YLIM),
                       clamp_coord(fifo_seg.x1, XLIM), clamp_coord(fifo_seg.y1, YLIM)};

    // fifo_rdreq is still high on the first StDLat cycle; fifo_q is valid on the second.
    assign hist_re = (state == StERd);
    assign hist_we = (state == StDLat) && !bus.fifo_rdreq && (wr_ptr < DEPTH_P);

    segment_history #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_history (
        .clk   (clk),
        .we    (hist_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (clamped),
        .re    (hist_re),
        .raddr (erase_ptr[AW-1:0]),
        .rdata (hist_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= StIdle;
            hist_count        <= '0;
            erase_ptr         <= '0;
            wr_ptr            <= '0;
            bus.fifo_rdreq    <= 1'b0;
            bus.ld_x0         <= '0;
            bus.ld_y0         <= '0;
            bus.ld_x1         <= '0;
            bus.ld_y1         <= '0;
            bus.ld_color      <= 1'b0;
            bus.ld_start      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.overflow      <= 1'b0;
            bus.frame_overrun <= 1'b0;
        end else begin
            bus.fifo_rdreq    <= 1'b0;
            bus.ld_start      <= 1'b0;
            bus.frame_overrun <= bus.frame_start && (state != StIdle);
            case (state)
                StIdle: begin
                    if (bus.frame_start) begin
                        state    <= (hist_count != '0) ? StERd : StDPop;
                        bus.busy <= 1'b1;
                    end
                end
                StERd: state <= StEGo;
                StEGo: begin
                    bus.ld_x0    <= hist_rdata.x0;
                    bus.ld_y0    <= hist_rdata.y0;
                    bus.ld_x1    <= hist_rdata.x1;
                    bus.ld_y1    <= hist_rdata.y1;
                    bus.ld_color <= 1'b0;
                    bus.ld_start <= 1'b1;
                    state        <= StEWait;
                end
                StEWait: begin
                    if (bus.ld_done) begin
                        if (erase_ptr + PW'(1) == hist_count) begin
                            erase_ptr <= '0;
                            state     <= StDPop;
                        end else begin
                            erase_ptr <= erase_ptr + PW'(1);
                            state     <= StERd;
                        end
                    end
                end
                StDPop: begin
                    if (bus.fifo_empty) begin
                        hist_count <= wr_ptr;
                        wr_ptr     <= '0;
                        bus.busy   <= 1'b0;
                        state      <= StIdle;
                    end else begin
                        bus.fifo_rdreq <= 1'b1;
                        state          <= StDLat;
                    end
                end
                StDLat: begin
                    if (!bus.fifo_rdreq) begin
                        bus.ld_x0    <= clamped.x0;
                        bus.ld_y0    <= clamped.y0;
                        bus.ld_x1    <= clamped.x1;
                        bus.ld_y1    <= clamped.y1;
                        bus.ld_color <= 1'b1;
                        bus.ld_start <= 1'b1;
                        if (wr_ptr < DEPTH_P) begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end else begin
                            bus.overflow <= 1'b1;
                        end
                        state <= StDWait;
                    end
                end
                StDWait: begin
                    if (bus.ld_done) begin
                        state <= StDPop;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_dispatcher.sv
// Bench for segment_dispatcher: FIFO and line_drawer models plus a frame-level reference
// of the expected line sequence (erase previous frame, then draw clamped new segments).
module tb_segment_dispatcher;
    import gfx_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int          CAP   = 1024;

    logic clk = 1'b0;
    logic reset;

    segment_dispatcher_if bus ();

    segment_dispatcher #(
        .DEPTH (DEPTH),
        .X_MAX (639),
        .Y_MAX (479)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [43:0] fifo_mem [CAP];
    int          rd_idx   = 0;
    int          wr_idx   = 0;
    logic [44:0] cap_line [CAP];
    int unsigned cap_cyc  [CAP];
    int          cap_n    = 0;
    int          dly      = 0;

    logic [43:0] prev [$];
    bit          exp_ovf = 1'b0;

    assign bus.fifo_empty = (rd_idx == wr_idx);

    // FIFO read data appears the cycle after rdreq; every ld_start is logged with its cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rdreq) begin
            bus.fifo_q <= fifo_mem[rd_idx % CAP];
            rd_idx     <= rd_idx + 1;
        end
        if (bus.ld_start && cap_n < CAP) begin
            cap_line[cap_n] <= {bus.ld_color, bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1};
            cap_cyc[cap_n]  <= cyc;
            cap_n           <= cap_n + 1;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dly         <= 0;
            bus.ld_done <= 1'b0;
        end else begin
            bus.ld_done <= 1'b0;
            if (bus.ld_start) begin
                dly <= int'($urandom_range(1, 4));
            end else if (dly == 1) begin
                bus.ld_done <= 1'b1;
                dly         <= 0;
            end else if (dly > 1) begin
                dly <= dly - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] lim(input logic [10:0] v, input int unsigned top);
        return (int'(v) > int'(top)) ? 11'(top) : v;
    endfunction

    function automatic logic [43:0] clamp_seg(input logic [43:0] s);
        return {lim(s[43:33], 639), lim(s[32:22], 479), lim(s[21:11], 639), lim(s[10:0], 479)};
    endfunction

    function automatic logic [43:0] mk(input int x0, input int y0, input int x1, input int y1);
        return {11'(x0), 11'(y0), 11'(x1), 11'(y1)};
    endfunction

    function automatic logic [43:0] rnd_seg();
        return mk(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
    endfunction

    task automatic run_frame(input logic [43:0] segs[$], input bit probe, input string name);
        logic [44:0] exp[$];
        logic [43:0] drawn[$];
        int          base;
        int unsigned fs_cyc;
        bit          probed = 1'b0;
        bit          done   = 1'b0;
        foreach (prev[i]) exp.push_back({1'b0, prev[i]});
        foreach (segs[i]) begin
            drawn.push_back(clamp_seg(segs[i]));
            exp.push_back({1'b1, clamp_seg(segs[i])});
            fifo_mem[wr_idx % CAP] = segs[i];
            wr_idx++;
        end
        base            = cap_n;
        bus.frame_start = 1'b1;
        fs_cyc          = cyc + 1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            if (probe && !probed && bus.ld_start && bus.ld_color) begin
                probed          = 1'b1;
                bus.frame_start = 1'b1;
                @(negedge clk);
                bus.frame_start = 1'b0;
                check({name, ":overrun_pulse"}, 64'(bus.frame_overrun), 64'd1);
                @(negedge clk);
                check({name, ":overrun_clear"}, 64'(bus.frame_overrun), 64'd0);
            end
            if (!bus.busy) done = 1'b1;
            else @(negedge clk);
        end
        check({name, ":finished"}, 64'(done), 64'd1);
        if (probe) check({name, ":probed"}, 64'(probed), 64'd1);
        check({name, ":line_count"}, 64'(cap_n - base), 64'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < cap_n; i++) begin
            check($sformatf("%s:line%0d", name, i), 64'(cap_line[base + i]), 64'(exp[i]));
        end
        if (exp.size() > 0 && cap_n > base) begin
            check({name, ":latency"}, 64'(cap_cyc[base] - fs_cyc),
                  (prev.size() > 0) ? 64'd2 : 64'd3);
        end
        if (segs.size() > DEPTH) exp_ovf = 1'b1;
        check({name, ":overflow"}, 64'(bus.overflow), 64'(exp_ovf));
        prev.delete();
        for (int i = 0; i < drawn.size() && i < DEPTH; i++) prev.push_back(drawn[i]);
    endtask

    initial begin
        logic [43:0] q[$];
        int          base;
        bit          found;
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ld_start", 64'(bus.ld_start), 64'd0);
        check("rst_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_coords", 64'({bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1, bus.ld_color}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        q = '{mk(0, 0, 10, 10), mk(5, 5, 5, 50)};
        run_frame(q, 1'b0, "first_frame");
        q = '{mk(700, 500, 3, 4)};
        run_frame(q, 1'b0, "erase_then_clamp");
        check("clamp_hold", 64'({bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1, bus.ld_color}),
              64'({11'd639, 11'd479, 11'd3, 11'd4, 1'b1}));

        for (int f = 0; f < 5; f++) begin
            q.delete();
            for (int s = 0; s < int'($urandom_range(0, 6)); s++) q.push_back(rnd_seg());
            run_frame(q, 1'b0, $sformatf("random%0d", f));
        end

        q.delete();
        for (int s = 0; s < DEPTH + 3; s++) q.push_back(rnd_seg());
        run_frame(q, 1'b0, "depth_plus3");
        q = '{rnd_seg()};
        run_frame(q, 1'b0, "erase_depth");

        q = '{rnd_seg(), rnd_seg(), rnd_seg()};
        run_frame(q, 1'b1, "overrun");
        base = cap_n;
        repeat (20) @(negedge clk);
        check("no_extra_pass_lines", 64'(cap_n - base), 64'd0);
        check("no_extra_pass_busy", 64'(bus.busy), 64'd0);

        // Abort an erase pass with reset while the drawer is busy.
        base            = cap_n;
        found           = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (bus.ld_start && !bus.ld_color) found = 1'b1;
            else @(negedge clk);
        end
        check("erase_seen_before_reset", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_start", 64'(bus.ld_start), 64'd0);
        check("async_rst_overflow", 64'(bus.overflow), 64'd0);
        check("async_rst_coords", 64'({bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1}), 64'd0);
        prev.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("aborted_lines", 64'(cap_n - base), 64'd0);
        @(negedge clk);
        q = '{rnd_seg(), rnd_seg()};
        run_frame(q, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
